// File: rtl/gcd_operand_loader_if.sv
// Handshake/data bundle between the operator front-end and the GCD core.
// master = loader side (drives operands and start), slave = environment/core side.
interface gcd_operand_loader_if #(
    parameter int W = 8
);
    logic         btn_load;
    logic         btn_go;
    logic [W-1:0] sw;
    logic [W-1:0] dip;
    logic         gcd_done;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         start;
    logic         ready;
    logic         err_zero;

    modport master (
        input  btn_load, btn_go, sw, dip, gcd_done,
        output op_a, op_b, start, ready, err_zero
    );

    modport slave (
        output btn_load, btn_go, sw, dip, gcd_done,
        input  op_a, op_b, start, ready, err_zero
    );
endinterface

// File: rtl/gcd_operand_loader.sv
// Operand loader for the GCD core: sync + debounce two buttons, capture sw/dip, issue start.
// Latency: button press acts 2+DEBOUNCE_CYCLES+1 cycles after raw edge; no backpressure, presses in WAIT are dropped.
module gcd_operand_loader #(
    parameter int W               = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gcd_operand_loader_if.master    bus
);
    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOADED = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    // Index 0 = load button, index 1 = go button.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stable;
    logic [1:0]    stable_d;
    logic [1:0]    press;
    logic [CW-1:0] cnt [2];

    logic [1:0]    state;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          start;
    logic          ready;
    logic          err_zero;

    assign raw = {bus.btn_go, bus.btn_load};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            press    <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            for (int i = 0; i < 2; i++) begin
                // A level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            start    <= 1'b0;
            ready    <= 1'b1;
            err_zero <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (press[0]) begin
                        op_a     <= bus.sw;
                        op_b     <= bus.dip;
                        err_zero <= 1'b0;
                        state    <= LOADED;
                    end
                end
                LOADED: begin
                    // Load has priority over a coincident go.
                    if (press[0]) begin
                        op_a     <= bus.sw;
                        op_b     <= bus.dip;
                        err_zero <= 1'b0;
                    end else if (press[1]) begin
                        if (op_a == '0 || op_b == '0) begin
                            err_zero <= 1'b1;
                        end else begin
                            start <= 1'b1;
                            ready <= 1'b0;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.gcd_done) begin
                        ready <= 1'b1;
                        state <= LOADED;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.op_a     = op_a;
    assign bus.op_b     = op_b;
    assign bus.start    = start;
    assign bus.ready    = ready;
    assign bus.err_zero = err_zero;
endmodule

// File: tb/tb_gcd_operand_loader.sv
// Bench for gcd_operand_loader with DEBOUNCE_CYCLES=4; start pulses are scored against
// operand pairs queued whenever a go press is expected to launch the core.
module tb_gcd_operand_loader;
    localparam int W = 8;
    localparam int D = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [2*W-1:0] sb_q [$];
    logic prev_start;

    gcd_operand_loader_if #(.W(W)) bus ();

    gcd_operand_loader #(.W(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start monitor: every start must match a queued operand pair and never repeat back-to-back.
    always @(posedge clk) begin
        #1;
        if (bus.start === 1'b1) begin
            check("start_single", {31'd0, prev_start}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_start", 32'd1, 32'd0);
            end else begin
                logic [2*W-1:0] exp_ops;
                exp_ops = sb_q.pop_front();
                check("start_ops", {16'd0, bus.op_a, bus.op_b}, {16'd0, exp_ops});
            end
        end
        prev_start = (bus.start === 1'b1);
    end

    task automatic press(input logic l, input logic g);
        @(negedge clk);
        bus.btn_load = l;
        bus.btn_go   = g;
        repeat (10) @(negedge clk);
        bus.btn_load = 1'b0;
        bus.btn_go   = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic done_pulse();
        @(negedge clk);
        bus.gcd_done = 1'b1;
        @(negedge clk);
        bus.gcd_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        prev_start   = 1'b0;
        rst_n        = 1'b0;
        bus.btn_load = 1'b0;
        bus.btn_go   = 1'b0;
        bus.sw       = 8'd77;
        bus.dip      = 8'd66;
        bus.gcd_done = 1'b0;

        // Reset state
        do_reset();
        check("rst_op_a", {24'd0, bus.op_a}, 32'd0);
        check("rst_op_b", {24'd0, bus.op_b}, 32'd0);
        check("rst_start", {31'd0, bus.start}, 32'd0);
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_err", {31'd0, bus.err_zero}, 32'd0);

        // Go in IDLE is ignored (any start would be flagged by the monitor)
        press(1'b0, 1'b1);
        check("idle_go_ready", {31'd0, bus.ready}, 32'd1);
        check("idle_go_op_a", {24'd0, bus.op_a}, 32'd0);

        // Bounce rejection: toggle every 2 cycles for 20 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.btn_load = ~bus.btn_load;
            @(negedge clk);
        end
        bus.btn_load = 1'b0;
        repeat (12) @(negedge clk);
        check("bounce_op_a", {24'd0, bus.op_a}, 32'd0);
        check("bounce_op_b", {24'd0, bus.op_b}, 32'd0);

        // Clean press: capture lands on the 8th rising edge after the raw change
        bus.sw  = 8'd10;
        bus.dip = 8'd5;
        @(negedge clk);
        bus.btn_load = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("lat_before_op_a", {24'd0, bus.op_a}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_op_a", {24'd0, bus.op_a}, 32'd10);
        check("lat_op_b", {24'd0, bus.op_b}, 32'd5);
        repeat (3) @(negedge clk);
        bus.btn_load = 1'b0;
        repeat (12) @(negedge clk);

        // Normal run 12/8
        bus.sw  = 8'd12;
        bus.dip = 8'd8;
        press(1'b1, 1'b0);
        sb_q.push_back({8'd12, 8'd8});
        press(1'b0, 1'b1);
        check("wait_ready", {31'd0, bus.ready}, 32'd0);
        bus.sw = 8'd3;
        press(1'b1, 1'b0);
        check("wait_hold_op_a", {24'd0, bus.op_a}, 32'd12);
        check("wait_ready2", {31'd0, bus.ready}, 32'd0);
        done_pulse();
        check("done_ready", {31'd0, bus.ready}, 32'd1);
        check("done_op_a", {24'd0, bus.op_a}, 32'd12);
        check("done_op_b", {24'd0, bus.op_b}, 32'd8);

        // Zero operand rejection, then recovery
        bus.sw  = 8'd0;
        bus.dip = 8'd7;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("zero_err", {31'd0, bus.err_zero}, 32'd1);
        check("zero_ready", {31'd0, bus.ready}, 32'd1);
        bus.sw = 8'd9;
        press(1'b1, 1'b0);
        check("reload_err", {31'd0, bus.err_zero}, 32'd0);
        sb_q.push_back({8'd9, 8'd7});
        press(1'b0, 1'b1);
        check("rerun_ready", {31'd0, bus.ready}, 32'd0);
        done_pulse();
        check("rerun_done_ready", {31'd0, bus.ready}, 32'd1);

        // Simultaneous load+go in LOADED: load wins
        bus.sw  = 8'd15;
        bus.dip = 8'd6;
        press(1'b1, 1'b1);
        check("sim_op_a", {24'd0, bus.op_a}, 32'd15);
        check("sim_op_b", {24'd0, bus.op_b}, 32'd6);
        check("sim_ready", {31'd0, bus.ready}, 32'd1);

        // Reset during WAIT, then a stale done
        sb_q.push_back({8'd15, 8'd6});
        press(1'b0, 1'b1);
        check("mid_wait_ready", {31'd0, bus.ready}, 32'd0);
        do_reset();
        done_pulse();
        repeat (3) @(negedge clk);
        check("post_rst_ready", {31'd0, bus.ready}, 32'd1);
        check("post_rst_op_a", {24'd0, bus.op_a}, 32'd0);
        check("post_rst_op_b", {24'd0, bus.op_b}, 32'd0);
        press(1'b0, 1'b1);
        check("post_rst_go_ready", {31'd0, bus.ready}, 32'd1);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
